fsm_driver: RTL and testbench

//  Initiator for the start/done control interface of `fsm`: accepts a job command (run length),

---
 rtl/fsm_driver_pkg.sv | 24 ++
 rtl/fsm_watchdog.sv | 36 +++
 rtl/fsm_driver.sv | 164 ++++++++++++++++
 tb/tb_fsm_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_driver_pkg.sv
// Shared definitions for the fsm_driver block.
//   - Driver FSM state encodings (3-bit).
//   - Response codes carried on rsp_err.
//   - Small helper used by the top to decide when the watchdog may count.
package fsm_driver_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TO_BUSY = 2'b01;
  localparam logic [1:0] RSP_TO_IDLE = 2'b10;

  // True in the two states where the driver is waiting on the controlled FSM.
  function automatic logic is_wait_state(input logic [2:0] s);
    return (s == S_WAIT_BUSY) || (s == S_WAIT_IDLE);
  endfunction

endpackage

// File: rtl/fsm_watchdog.sv
// Watchdog counter for the driver's wait states.
// Ports:
//   clock    in  clock
//   reset    in  synchronous, active-high reset
//   clear    in  restart the count at zero
//   enable   in  advance the count by one this cycle
//   expired  out count has reached TIMEOUT-1 (last permitted wait cycle)
module fsm_watchdog #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wd_q;

  // Count saturates at the limit; the driver leaves the wait state when expired anyway.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
    end else if (clear) begin
      wd_q <= '0;
    end else if (enable && !expired) begin
      wd_q <= wd_q + TO_W'(1);
    end
  end

  assign expired = (wd_q == Limit);

endmodule

// File: rtl/fsm_driver.sv
// Initiator for the start/done control interface of a controlled FSM.
// Accepts a job (run length), pulses start, waits for busy, holds for the requested
// number of cycles, pulses done, waits for idle, then offers a status response.
// A watchdog bounds both waits and reports which one timed out.
// Ports:
//   clock      in   clock
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  driver can accept a command (idle only)
//   cmd_len    in   extra busy cycles before done, sampled on the command handshake
//   rsp_valid  out  response available, held until accepted
//   rsp_ready  in   upstream accepts the response
//   rsp_err    out  00 ok, 01 busy timeout, 10 idle timeout; stable while rsp_valid
//   start      out  one-cycle pulse to the controlled FSM
//   done       out  one-cycle pulse to the controlled FSM
//   state      in   state code reported by the controlled FSM
//   job_count  out  responses accepted (wraps)
//   err_count  out  accepted responses with a non-zero rsp_err (wraps)
module fsm_driver
  import fsm_driver_pkg::*;
#(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned TO_W      = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [7:0]  IDLE_CODE = 8'd0,
  parameter logic [7:0]  BUSY_CODE = 8'd1,
  parameter int unsigned JCNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_err,
  output logic              start,
  output logic              done,
  input  logic [7:0]        state,
  output logic [JCNT_W-1:0] job_count,
  output logic [JCNT_W-1:0] err_count
);

  logic [2:0]        fsm_q, fsm_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [JCNT_W-1:0] job_count_q, job_count_d;
  logic [JCNT_W-1:0] err_count_q, err_count_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  fsm_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    fsm_d       = fsm_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    job_count_d = job_count_q;
    err_count_d = err_count_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d = cmd_len;
          fsm_d = S_START;
        end
      end
      S_START: begin
        wd_clear = 1'b1;
        fsm_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A match on the last watchdog cycle still counts as success.
        if (state == BUSY_CODE) begin
          cnt_d = len_q;
          fsm_d = S_RUN;
        end else if (wd_expired) begin
          rsp_err_d = RSP_TO_BUSY;
          fsm_d     = S_RESP;
        end else begin
          wd_enable = is_wait_state(fsm_q);
        end
      end
      S_RUN: begin
        // Terminates on zero before decrementing, so cmd_len=max cannot underflow.
        if (cnt_q == '0) begin
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_DONE: begin
        wd_clear = 1'b1;
        fsm_d    = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (state == IDLE_CODE) begin
          rsp_err_d = RSP_OK;
          fsm_d     = S_RESP;
        end else if (wd_expired) begin
          rsp_err_d = RSP_TO_IDLE;
          fsm_d     = S_RESP;
        end else begin
          wd_enable = is_wait_state(fsm_q);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          job_count_d = job_count_q + JCNT_W'(1);
          if (rsp_err_q != RSP_OK) begin
            err_count_d = err_count_q + JCNT_W'(1);
          end
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= RSP_OK;
      job_count_q <= '0;
      err_count_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      job_count_q <= job_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Handshake and pulse outputs decode the state register only.
  assign cmd_ready = (fsm_q == S_IDLE);
  assign start     = (fsm_q == S_START);
  assign done      = (fsm_q == S_DONE);
  assign rsp_valid = (fsm_q == S_RESP);
  assign rsp_err   = rsp_err_q;
  assign job_count = job_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_fsm_driver.sv
// Self-checking bench for fsm_driver. The controlled FSM is a small stub driven by the
// bench: it reports busy b cycles after start (b=0: already busy) and idle i cycles
// after done. Expected timings come from a cycle-timeline model of the job protocol.
module tb_fsm_driver;
  import fsm_driver_pkg::*;

  localparam int LEN_W   = 8;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 16;
  localparam int JCNT_W  = 4;
  localparam int JMOD    = 1 << JCNT_W;
  localparam int NEVER   = 1000;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_err;
  logic              start;
  logic              done;
  logic [7:0]        state;
  logic [JCNT_W-1:0] job_count;
  logic [JCNT_W-1:0] err_count;

  fsm_driver #(
    .LEN_W     (LEN_W),
    .TO_W      (TO_W),
    .TIMEOUT   (TIMEOUT),
    .IDLE_CODE (8'd0),
    .BUSY_CODE (8'd1),
    .JCNT_W    (JCNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .start     (start),
    .done      (done),
    .state     (state),
    .job_count (job_count),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int model_jobs = 0;
  int model_errs = 0;

  typedef struct {
    int         len;
    int         b;
    int         i;
    int         rdelay;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline of a job whose start pulse is in cycle 1 (handshake in cycle 0).
  function automatic void predict(input int len, input int b, input int i,
                                  output int done_c, output int rsp_c,
                                  output logic [1:0] err);
    int bb;
    int busy_seen;
    bb = (b < 1) ? 1 : b;
    if (bb <= TIMEOUT) begin
      busy_seen = 1 + bb;               // wait-busy window is cycles 2..TIMEOUT+1
      done_c = busy_seen + len + 2;     // len+1 run cycles follow the busy match
      if (i <= TIMEOUT) begin
        rsp_c = done_c + i + 1;
        err   = RSP_OK;
      end else begin
        rsp_c = done_c + TIMEOUT + 1;
        err   = RSP_TO_IDLE;
      end
    end else begin
      done_c = -1;
      rsp_c  = TIMEOUT + 2;
      err    = RSP_TO_BUSY;
    end
  endfunction

  // Runs one job starting at a negedge with the DUT idle; exp_err=2'b11 uses the model.
  task automatic run_job(input string tag, input int len, input int b, input int i,
                         input int rdelay, input logic [1:0] exp_err_in);
    int exp_done, exp_rsp, limit;
    int st_c, dn_c, rv_c, n_st, n_dn, overlap, unstable;
    bit acc, busy;
    logic [1:0] model_err, exp_err, err_seen;
    predict(len, b, i, exp_done, exp_rsp, model_err);
    exp_err = (exp_err_in == 2'b11) ? model_err : exp_err_in;
    st_c = -1; dn_c = -1; rv_c = -1; n_st = 0; n_dn = 0; overlap = 0; unstable = 0;
    acc = 1'b0; err_seen = 2'b11;
    limit = len + 3 * TIMEOUT + rdelay + 16;
    check({tag, ".cmd_ready_before"}, int'(cmd_ready), 1);
    for (int k = 0; k < limit && !acc; k++) begin
      if (k > 0) @(negedge clock);
      busy = (b == 0) || (st_c >= 0 && k >= st_c + b);
      if (dn_c >= 0 && k >= dn_c + i) busy = 1'b0;
      state     = busy ? 8'd1 : 8'd0;
      cmd_valid = (k == 0);
      if (k == 0) cmd_len = LEN_W'(len);
      rsp_ready = 1'b0;
      if (start) begin n_st++; if (st_c < 0) st_c = k; end
      if (done)  begin n_dn++; if (dn_c < 0) dn_c = k; end
      if (start && done) overlap++;
      if (rsp_valid) begin
        if (rv_c < 0) begin
          rv_c = k;
          err_seen = rsp_err;
        end else if (rsp_err != err_seen) begin
          unstable++;
        end
        if (cmd_ready) unstable++;
        if (k - rv_c < rdelay) begin
          // A command offered while the response is pending must be ignored.
          cmd_valid = 1'b1;
          cmd_len   = LEN_W'($urandom);
        end else begin
          rsp_ready = 1'b1;
          acc = 1'b1;
        end
      end else if (rv_c >= 0) begin
        unstable++;
      end
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    state     = 8'd0;
    if (acc) begin
      model_jobs++;
      if (exp_err != RSP_OK) model_errs++;
    end
    check({tag, ".accepted"},     int'(acc), 1);
    check({tag, ".start_cycle"},  st_c, 1);
    check({tag, ".start_pulses"}, n_st, 1);
    check({tag, ".done_cycle"},   dn_c, exp_done);
    check({tag, ".done_pulses"},  n_dn, (exp_done >= 0) ? 1 : 0);
    check({tag, ".rsp_cycle"},    rv_c, exp_rsp);
    check({tag, ".rsp_err"},      int'(err_seen), int'(exp_err));
    check({tag, ".overlap"},      overlap, 0);
    check({tag, ".rsp_stable"},   unstable, 0);
    check({tag, ".job_count"},    int'(job_count), model_jobs % JMOD);
    check({tag, ".err_count"},    int'(err_count), model_errs % JMOD);
    check({tag, ".idle_after"},   int'(cmd_ready), 1);
    check({tag, ".rsp_low_after"}, int'(rsp_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; rsp_ready = 1'b0; state = 8'd0;

    vecs[0] = '{len: 0,   b: 1,       i: 1,           rdelay: 0,  err: RSP_OK};
    vecs[1] = '{len: 5,   b: 1,       i: 1,           rdelay: 0,  err: RSP_OK};
    vecs[2] = '{len: 0,   b: NEVER,   i: 1,           rdelay: 0,  err: RSP_TO_BUSY};
    vecs[3] = '{len: 3,   b: 0,       i: NEVER,       rdelay: 0,  err: RSP_TO_IDLE};
    vecs[4] = '{len: 4,   b: 2,       i: 3,           rdelay: 10, err: RSP_OK};
    vecs[5] = '{len: 2,   b: TIMEOUT, i: TIMEOUT,     rdelay: 0,  err: RSP_OK};
    vecs[6] = '{len: 2,   b: TIMEOUT + 1, i: 1,       rdelay: 0,  err: RSP_TO_BUSY};
    vecs[7] = '{len: 1,   b: 1,       i: TIMEOUT + 1, rdelay: 2,  err: RSP_TO_IDLE};
    vecs[8] = '{len: 7,   b: 0,       i: 2,           rdelay: 1,  err: RSP_OK};
    vecs[9] = '{len: 255, b: 1,       i: 1,           rdelay: 0,  err: RSP_OK};

    repeat (16) @(negedge clock);
    check("reset.start",     int'(start), 0);
    check("reset.done",      int'(done), 0);
    check("reset.rsp_valid", int'(rsp_valid), 0);
    check("reset.rsp_err",   int'(rsp_err), 0);
    check("reset.job_count", int'(job_count), 0);
    check("reset.err_count", int'(err_count), 0);
    check("reset.cmd_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 10; v++) begin
      run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].b, vecs[v].i,
              vecs[v].rdelay, vecs[v].err);
    end

    for (int r = 0; r < 40; r++) begin
      run_job($sformatf("rnd%0d", r), $urandom_range(0, 12), $urandom_range(0, TIMEOUT + 3),
              $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 4), 2'b11);
    end

    // Reset in the middle of a long run: the job is abandoned without a response.
    state = 8'd0; cmd_valid = 1'b1; cmd_len = LEN_W'(20);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("abort.start", int'(start), 1);
    state = 8'd1;
    repeat (6) @(negedge clock);
    check("abort.busy_before_reset", int'(cmd_ready), 0);
    reset = 1'b1;
    @(negedge clock);
    check("abort.start_low",  int'(start), 0);
    check("abort.done_low",   int'(done), 0);
    check("abort.rsp_low",    int'(rsp_valid), 0);
    check("abort.job_count",  int'(job_count), 0);
    check("abort.err_count",  int'(err_count), 0);
    check("abort.cmd_ready",  int'(cmd_ready), 1);
    reset = 1'b0;
    state = 8'd0;
    model_jobs = 0;
    model_errs = 0;
    @(negedge clock);
    check("abort.no_resp", int'(rsp_valid), 0);
    run_job("post_reset", 1, 1, 1, 0, RSP_OK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
